imem_bus_arbiter: RTL and testbench
===================================

Name: imem_bus_arbiter

Overview:
- Shares the single memory bus between the data cache, the instruction cache miss path and the instruction prefetcher. The memory bus has 4-bit tagged split transactions.
- Selects one requester per cycle. The memory's accept/reject response goes back to the granted requester in the same cycle.
- A registered tag-ownership table routes each returning load tag to the requester that issued it.
- Also generates the prefetcher's give_way signal and prevents prefetch starvation.

Parameters:
- XLEN, 32, address width.
- STARVE_LIMIT, 8, number of consecutive denied prefetch cycles before the prefetcher is promoted above the icache.
- NTAG, 16, tag space. Tag 0 is reserved for "none".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- dcache_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- dcache_addr  in  XLEN  dcache request address
- dcache_data  in  64  store data
- icache_command  in  2  BUS_NONE/BUS_LOAD
- icache_addr  in  XLEN  icache miss address
- pref_command  in  2  BUS_NONE/BUS_LOAD
- pref_addr  in  XLEN  prefetch address
- mem2proc_response  in  4  memory accept tag, 0 = reject
- mem2proc_data  in  64  returning data
- mem2proc_tag  in  4  returning tag, 0 = no data
- proc2mem_command  out  2  forwarded command
- proc2mem_addr  out  XLEN  forwarded address
- proc2mem_data  out  64  forwarded store data
- dcache_response  out  4  accept tag to dcache
- icache_response  out  4  accept tag to icache
- pref_response  out  4  accept tag to prefetcher
- dcache_tag  out  4  returning tag routed to dcache
- icache_tag  out  4  returning tag routed to icache
- pref_tag  out  4  returning tag routed to prefetcher
- rd_data  out  64  mem2proc_data passthrough, shared by all requesters
- pref_give_way  out  1  prefetch lost arbitration this cycle

Behaviour:
- Clock/reset: reset reset, synchronous, active-high; clock clock.
- Reset state:
  - owner table: all entries INVALID.
  - starve_cnt = 0.
  - All outputs are combinational and are forced while reset is high: proc2mem_command = BUS_NONE, proc2mem_addr/data = 0, all *_response = 0, all *_tag = 0, pref_give_way = 0.
- Arbitration (combinational, same cycle):
  - Default priority is dcache > icache > prefetch.
  - If starve_cnt == STARVE_LIMIT, priority becomes dcache > prefetch > icache.
  - The winner's command and address drive proc2mem_*. proc2mem_data = dcache_data only when the dcache wins; otherwise 0.
  - No requester active: BUS_NONE, addr 0.
- Response routing:
  - mem2proc_response is copied to the winner's *_response. Every other *_response = 0.
  - A loser therefore sees 0, which it treats as a reject and retries.
- pref_give_way = 1 iff pref_command == BUS_LOAD and the prefetcher is not the winner.
- Owner table (NTAG entries, 2-bit code: INVALID/DCACHE/ICACHE/PREF), updated at posedge:
  - Issue: if the winner's command is BUS_LOAD and mem2proc_response != 0, set owner[mem2proc_response] = winner. Store accepts are never recorded.
  - Return: if mem2proc_tag != 0 and owner[mem2proc_tag] != INVALID, that owner's *_tag = mem2proc_tag in the same cycle and the entry is cleared at the clock edge. Other *_tag outputs = 0.
  - Unknown or INVALID return tags are dropped: all *_tag = 0.
  - Same tag returned and reissued in one cycle: the return is routed using the old owner, and the new owner is written. The write wins.
  - Issue to an already-valid entry (memory tag reuse error): overwrite.
- Starvation counter (8-bit, saturating at STARVE_LIMIT):
  - Increment when pref_command == BUS_LOAD and the prefetcher is not the winner.
  - Clear when the prefetcher wins, whether accepted or rejected.
  - Clear when pref_command == BUS_NONE.
  - Promotion lasts exactly the cycles where starve_cnt == STARVE_LIMIT, so it ends once the prefetcher wins.
- Reset mid-transaction: the table is cleared, so any later return of an in-flight tag is dropped.
- Latency:
  - Grant and response: 0 cycles, combinational.
  - Return routing: 0 cycles from mem2proc_tag.
  - Table visible: next cycle.

Test Plan:
- Only icache_command = LOAD, addr 0x100, response 3 -> proc2mem_addr = 0x100, icache_response = 3. Two cycles later mem2proc_tag = 3 -> icache_tag = 3, dcache_tag = pref_tag = 0, entry 3 cleared.
- dcache LOAD, icache LOAD and pref LOAD in the same cycle, response 5 -> dcache_response = 5, icache_response = 0, pref_response = 0, pref_give_way = 1. Tag 5 later routes to dcache.
- dcache STORE accepted with tag 7, then mem2proc_tag = 7 -> all *_tag = 0. A stray mem2proc_tag = 9 is also dropped.
- icache and pref both LOAD continuously for 8 cycles -> starve_cnt = 8. Cycle 9: prefetcher wins, pref_response = memory response, pref_give_way = 0. Cycle 10: icache wins again.
- Same cycle: return of tag 4 (owner ICACHE) and pref issue accepted with tag 4 -> icache_tag = 4 now. Next return of tag 4 goes to pref_tag.
- pref accepted with tag 2, reset pulse, then mem2proc_tag = 2 -> all *_tag = 0. After reset release, all outputs 0 and proc2mem_command = BUS_NONE.

Source files
------------

// File: rtl/imem_bus_arbiter_if.sv
// Request/response bundle between the three bus requesters, the memory bus and the arbiter.
// The arbiter uses the slave view; requesters and memory together drive the master view.
interface imem_bus_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      dcache_command;
    logic [XLEN-1:0] dcache_addr;
    logic [63:0]     dcache_data;
    logic [1:0]      icache_command;
    logic [XLEN-1:0] icache_addr;
    logic [1:0]      pref_command;
    logic [XLEN-1:0] pref_addr;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      dcache_response;
    logic [3:0]      icache_response;
    logic [3:0]      pref_response;
    logic [3:0]      dcache_tag;
    logic [3:0]      icache_tag;
    logic [3:0]      pref_tag;
    logic [63:0]     rd_data;
    logic            pref_give_way;

    modport master (
        output dcache_command, dcache_addr, dcache_data, icache_command, icache_addr,
               pref_command, pref_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, dcache_response,
               icache_response, pref_response, dcache_tag, icache_tag, pref_tag, rd_data,
               pref_give_way
    );

    modport slave (
        input  dcache_command, dcache_addr, dcache_data, icache_command, icache_addr,
               pref_command, pref_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data, dcache_response,
               icache_response, pref_response, dcache_tag, icache_tag, pref_tag, rd_data,
               pref_give_way
    );
endinterface

// File: rtl/imem_bus_arbiter.sv
// Memory bus arbiter for dcache, icache miss path and prefetcher, with a tag-ownership
// table that routes returning load tags back to their issuer.
module imem_bus_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned NTAG         = 16
) (
    input logic               clock,
    input logic               reset,
    imem_bus_arbiter_if.slave bus
);
    // Bus command encoding: 0 = none, 1 = load, 2 = store.
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {
        OwnInvalid = 2'd0,
        OwnDcache  = 2'd1,
        OwnIcache  = 2'd2,
        OwnPref    = 2'd3
    } owner_e;

    owner_e          owner_q [NTAG];
    owner_e          owner_d [NTAG];
    logic [7:0]      starve_q, starve_d;
    owner_e          winner;
    owner_e          ret_owner;
    logic            promote;
    logic [1:0]      win_cmd;
    logic [XLEN-1:0] win_addr;

    // Arbitration: the prefetcher jumps the icache only while the counter sits at the limit.
    always_comb begin
        promote  = (starve_q == 8'(STARVE_LIMIT));
        winner   = OwnInvalid;
        win_cmd  = BUS_NONE;
        win_addr = '0;
        if (bus.dcache_command != BUS_NONE) begin
            winner = OwnDcache;
        end else if (promote && bus.pref_command != BUS_NONE) begin
            winner = OwnPref;
        end else if (bus.icache_command != BUS_NONE) begin
            winner = OwnIcache;
        end else if (bus.pref_command != BUS_NONE) begin
            winner = OwnPref;
        end
        unique case (winner)
            OwnDcache: begin win_cmd = bus.dcache_command; win_addr = bus.dcache_addr; end
            OwnIcache: begin win_cmd = bus.icache_command; win_addr = bus.icache_addr; end
            OwnPref:   begin win_cmd = bus.pref_command;   win_addr = bus.pref_addr;   end
            default:   begin win_cmd = BUS_NONE;           win_addr = '0;              end
        endcase
        ret_owner = (bus.mem2proc_tag != 4'd0) ? owner_q[bus.mem2proc_tag] : OwnInvalid;
    end

    // Return clears its entry first so a same-cycle reissue of that tag overwrites it.
    always_comb begin
        owner_d = owner_q;
        if (ret_owner != OwnInvalid) begin
            owner_d[bus.mem2proc_tag] = OwnInvalid;
        end
        if (win_cmd == BUS_LOAD && bus.mem2proc_response != 4'd0) begin
            owner_d[bus.mem2proc_response] = winner;
        end
        starve_d = starve_q;
        if (winner == OwnPref || bus.pref_command == BUS_NONE) begin
            starve_d = 8'd0;
        end else if (bus.pref_command == BUS_LOAD && !promote) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NTAG; i++) begin
                owner_q[i] <= OwnInvalid;
            end
            starve_q <= 8'd0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.dcache_response  = 4'd0;
        bus.icache_response  = 4'd0;
        bus.pref_response    = 4'd0;
        bus.dcache_tag       = 4'd0;
        bus.icache_tag       = 4'd0;
        bus.pref_tag         = 4'd0;
        bus.rd_data          = '0;
        bus.pref_give_way    = 1'b0;
        if (!reset) begin
            bus.proc2mem_command = win_cmd;
            bus.proc2mem_addr    = win_addr;
            bus.proc2mem_data    = (winner == OwnDcache) ? bus.dcache_data : 64'd0;
            bus.rd_data          = bus.mem2proc_data;
            bus.pref_give_way    = (bus.pref_command == BUS_LOAD) && (winner != OwnPref);
            unique case (winner)
                OwnDcache: bus.dcache_response = bus.mem2proc_response;
                OwnIcache: bus.icache_response = bus.mem2proc_response;
                OwnPref:   bus.pref_response   = bus.mem2proc_response;
                default:   ;
            endcase
            unique case (ret_owner)
                OwnDcache: bus.dcache_tag = bus.mem2proc_tag;
                OwnIcache: bus.icache_tag = bus.mem2proc_tag;
                OwnPref:   bus.pref_tag   = bus.mem2proc_tag;
                default:   ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_bus_arbiter.sv
// Self-checking bench for imem_bus_arbiter; issued loads are recorded in a scoreboard
// and checked against the tag routing when memory returns them.
module tb_imem_bus_arbiter;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] O_NONE = 2'd0, O_D = 2'd1, O_I = 2'd2, O_P = 2'd3;

    typedef struct packed {
        logic [3:0] tag;
        logic [1:0] owner;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    sb_t  sb_q[$];

    imem_bus_arbiter_if #(.XLEN(32)) bus ();

    imem_bus_arbiter #(.XLEN(32), .STARVE_LIMIT(8), .NTAG(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] exp_tags(input logic [1:0] own, input logic [3:0] tag);
        case (own)
            O_D:     return {tag, 4'd0, 4'd0};
            O_I:     return {4'd0, tag, 4'd0};
            O_P:     return {4'd0, 4'd0, tag};
            default: return 12'd0;
        endcase
    endfunction

    task automatic idle();
        bus.dcache_command = BUS_NONE; bus.dcache_addr = '0; bus.dcache_data = '0;
        bus.icache_command = BUS_NONE; bus.icache_addr = '0;
        bus.pref_command = BUS_NONE; bus.pref_addr = '0;
        bus.mem2proc_response = 4'd0; bus.mem2proc_tag = 4'd0; bus.mem2proc_data = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] got;
        reset = 1'b1;
        idle();
        bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h100; bus.pref_command = BUS_LOAD;
        bus.mem2proc_response = 4'd3; bus.mem2proc_tag = 4'd3;
        @(negedge clock);
        total++;
        if (bus.proc2mem_command !== BUS_NONE || bus.proc2mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus: got cmd=%0d addr=%h want 0/0", bus.proc2mem_command,
                     bus.proc2mem_addr);
        end
        got = {bus.dcache_response, bus.icache_response, bus.pref_response,
               bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (got !== 24'd0) begin
            bad++; $display("FAIL reset_resp_tags: got %h want 0", got);
        end
        total++;
        if (bus.pref_give_way !== 1'b0) begin
            bad++; $display("FAIL reset_give_way: got %b want 0", bus.pref_give_way);
        end
        step();
        reset = 1'b0;
        idle();
        @(negedge clock);
        got = {bus.dcache_response, bus.icache_response, bus.pref_response,
               bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (bus.proc2mem_command !== BUS_NONE || got !== 24'd0 || bus.pref_give_way !== 1'b0)
        begin
            bad++;
            $display("FAIL post_reset_idle: got cmd=%0d resp_tags=%h gw=%b want 0/0/0",
                     bus.proc2mem_command, got, bus.pref_give_way);
        end
        step();
    endtask

    task automatic test_icache_load();
        sb_t e;
        logic [11:0] got;
        idle();
        bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h100; bus.dcache_data = 64'h1111;
        bus.mem2proc_response = 4'd3;
        sb_q.push_back('{tag: 4'd3, owner: O_I});
        @(negedge clock);
        total++;
        if (bus.proc2mem_addr !== 32'h100 || bus.proc2mem_command !== BUS_LOAD) begin
            bad++;
            $display("FAIL ic_addr: got %h/%0d want 100/1", bus.proc2mem_addr,
                     bus.proc2mem_command);
        end
        total++;
        if ({bus.dcache_response, bus.icache_response, bus.pref_response} !== 12'h030) begin
            bad++;
            $display("FAIL ic_resp: got %h want 030",
                     {bus.dcache_response, bus.icache_response, bus.pref_response});
        end
        total++;
        if (bus.proc2mem_data !== 64'd0) begin
            bad++; $display("FAIL ic_data: got %h want 0", bus.proc2mem_data);
        end
        step();
        idle();
        step();
        bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hCAFE;
        @(negedge clock);
        got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL ic_return: got %h want scoreboard entry", got);
        end else begin
            e = sb_q.pop_front();
            if (got !== exp_tags(e.owner, e.tag)) begin
                bad++; $display("FAIL ic_return: got %h want %h", got, exp_tags(e.owner, e.tag));
            end
        end
        total++;
        if (bus.rd_data !== 64'hCAFE) begin
            bad++; $display("FAIL rd_data: got %h want cafe", bus.rd_data);
        end
        step();
        // Entry must have been cleared by the first return.
        sb_q.push_back('{tag: 4'd3, owner: O_NONE});
        @(negedge clock);
        got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL ic_cleared: got %h want scoreboard entry", got);
        end else begin
            e = sb_q.pop_front();
            if (got !== exp_tags(e.owner, e.tag)) begin
                bad++; $display("FAIL ic_cleared: got %h want %h", got, exp_tags(e.owner, e.tag));
            end
        end
        step();
    endtask

    task automatic test_priority();
        sb_t e;
        logic [11:0] got;
        idle();
        bus.dcache_command = BUS_LOAD; bus.dcache_addr = 32'hD00; bus.dcache_data = 64'h55;
        bus.icache_command = BUS_LOAD; bus.icache_addr = 32'hC00;
        bus.pref_command = BUS_LOAD; bus.pref_addr = 32'hE00;
        bus.mem2proc_response = 4'd5;
        sb_q.push_back('{tag: 4'd5, owner: O_D});
        @(negedge clock);
        total++;
        if ({bus.dcache_response, bus.icache_response, bus.pref_response} !== 12'h500) begin
            bad++;
            $display("FAIL prio_resp: got %h want 500",
                     {bus.dcache_response, bus.icache_response, bus.pref_response});
        end
        total++;
        if (bus.proc2mem_addr !== 32'hD00 || bus.proc2mem_data !== 64'h55) begin
            bad++;
            $display("FAIL prio_bus: got %h/%h want d00/55", bus.proc2mem_addr,
                     bus.proc2mem_data);
        end
        total++;
        if (bus.pref_give_way !== 1'b1) begin
            bad++; $display("FAIL prio_give_way: got %b want 1", bus.pref_give_way);
        end
        step();
        idle();
        bus.mem2proc_tag = 4'd5;
        @(negedge clock);
        got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL prio_return: got %h want scoreboard entry", got);
        end else begin
            e = sb_q.pop_front();
            if (got !== exp_tags(e.owner, e.tag)) begin
                bad++;
                $display("FAIL prio_return: got %h want %h", got, exp_tags(e.owner, e.tag));
            end
        end
        step();
    endtask

    task automatic test_store_drop();
        sb_t e;
        logic [11:0] got;
        idle();
        bus.dcache_command = BUS_STORE; bus.dcache_addr = 32'hA0; bus.dcache_data = 64'h77;
        bus.mem2proc_response = 4'd7;
        @(negedge clock);
        total++;
        if (bus.proc2mem_command !== BUS_STORE || bus.dcache_response !== 4'd7) begin
            bad++;
            $display("FAIL store_issue: got cmd=%0d resp=%0d want 2/7", bus.proc2mem_command,
                     bus.dcache_response);
        end
        step();
        idle();
        sb_q.push_back('{tag: 4'd7, owner: O_NONE});
        sb_q.push_back('{tag: 4'd9, owner: O_NONE});
        for (int k = 0; k < 2; k++) begin
            bus.mem2proc_tag = (k == 0) ? 4'd7 : 4'd9;
            @(negedge clock);
            got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
            total++;
            if (sb_q.size() == 0) begin
                bad++; $display("FAIL drop_%0d: got %h want scoreboard entry", k, got);
            end else begin
                e = sb_q.pop_front();
                if (got !== exp_tags(e.owner, e.tag)) begin
                    bad++;
                    $display("FAIL drop_%0d: got %h want %h", k, got, exp_tags(e.owner, e.tag));
                end
            end
            step();
        end
    endtask

    task automatic test_starvation();
        sb_t e;
        logic [11:0] got;
        int model_starve = 0;
        bit pref_wins;
        idle();
        bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h200;
        bus.pref_command = BUS_LOAD; bus.pref_addr = 32'h300;
        for (int c = 0; c < 10; c++) begin
            pref_wins = (model_starve == 8);
            bus.mem2proc_response = pref_wins ? 4'd6 : 4'd1;
            if (pref_wins) sb_q.push_back('{tag: 4'd6, owner: O_P});
            @(negedge clock);
            total++;
            if (bus.proc2mem_addr !== (pref_wins ? 32'h300 : 32'h200)) begin
                bad++; $display("FAIL starve_addr_%0d: got %h", c, bus.proc2mem_addr);
            end
            total++;
            if (bus.pref_give_way !== !pref_wins) begin
                bad++;
                $display("FAIL starve_gw_%0d: got %b want %b", c, bus.pref_give_way, !pref_wins);
            end
            total++;
            if ({bus.icache_response, bus.pref_response} !== (pref_wins ? 8'h06 : 8'h10)) begin
                bad++;
                $display("FAIL starve_resp_%0d: got %h want %h", c,
                         {bus.icache_response, bus.pref_response},
                         (pref_wins ? 8'h06 : 8'h10));
            end
            model_starve = pref_wins ? 0 : ((model_starve == 8) ? 8 : model_starve + 1);
            step();
        end
        idle();
        bus.mem2proc_tag = 4'd6;
        @(negedge clock);
        got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL starve_return: got %h want scoreboard entry", got);
        end else begin
            e = sb_q.pop_front();
            if (got !== exp_tags(e.owner, e.tag)) begin
                bad++;
                $display("FAIL starve_return: got %h want %h", got, exp_tags(e.owner, e.tag));
            end
        end
        step();
    endtask

    task automatic test_same_cycle();
        sb_t e;
        logic [11:0] got;
        idle();
        bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h400; bus.mem2proc_response = 4'd4;
        sb_q.push_back('{tag: 4'd4, owner: O_I});
        step();
        idle();
        bus.pref_command = BUS_LOAD; bus.pref_addr = 32'h500; bus.mem2proc_response = 4'd4;
        bus.mem2proc_tag = 4'd4;
        @(negedge clock);
        total++;
        if (bus.pref_response !== 4'd4) begin
            bad++; $display("FAIL reuse_resp: got %0d want 4", bus.pref_response);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                step();
                idle();
                bus.mem2proc_tag = 4'd4;
                @(negedge clock);
            end
            got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
            total++;
            if (sb_q.size() == 0) begin
                bad++; $display("FAIL reuse_ret_%0d: got %h want scoreboard entry", k, got);
            end else begin
                e = sb_q.pop_front();
                if (got !== exp_tags(e.owner, e.tag)) begin
                    bad++;
                    $display("FAIL reuse_ret_%0d: got %h want %h", k, got,
                             exp_tags(e.owner, e.tag));
                end
            end
            if (k == 0) sb_q.push_back('{tag: 4'd4, owner: O_P});
        end
        step();
    endtask

    task automatic test_reset_midflight();
        sb_t e;
        logic [11:0] got;
        idle();
        bus.pref_command = BUS_LOAD; bus.pref_addr = 32'h600; bus.mem2proc_response = 4'd2;
        @(negedge clock);
        total++;
        if (bus.pref_response !== 4'd2) begin
            bad++; $display("FAIL mid_issue: got %0d want 2", bus.pref_response);
        end
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (bus.proc2mem_command !== BUS_NONE || bus.pref_give_way !== 1'b0 ||
            {bus.dcache_response, bus.icache_response, bus.pref_response} !== 12'd0) begin
            bad++;
            $display("FAIL mid_release: got cmd=%0d gw=%b want 0/0", bus.proc2mem_command,
                     bus.pref_give_way);
        end
        step();
        bus.mem2proc_tag = 4'd2;
        sb_q.push_back('{tag: 4'd2, owner: O_NONE});
        @(negedge clock);
        got = {bus.dcache_tag, bus.icache_tag, bus.pref_tag};
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL mid_return: got %h want scoreboard entry", got);
        end else begin
            e = sb_q.pop_front();
            if (got !== exp_tags(e.owner, e.tag)) begin
                bad++; $display("FAIL mid_return: got %h want %h", got, exp_tags(e.owner, e.tag));
            end
        end
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        test_reset();
        test_icache_load();
        test_priority();
        test_store_drop();
        test_starvation();
        test_same_cycle();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
